// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter in front of a single-port data memory.
// One access issues per cycle; the winner gets a one-cycle gnt pulse and the
// memory port (daddr/dwdata/dwe/dre) is loaded on the same edge. Read data
// returning one cycle after dre is routed to whichever requester issued it.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   m0_* / m1_*                 requester ports (req/addr/wdata/we in,
//                               gnt/rvalid/rdata out)
//   daddr, dwdata, dwe, dre     registered memory command
//   drdata                      memory read data
//
// Build option: define DMEM_ARB_RR_EN for round-robin tie-breaking; without
// it requester 0 wins every tie.
module dmem_arbiter #(
    parameter int unsigned AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic [3:0]    m0_we,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic [3:0]    m1_we,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic [AW-1:0] daddr,
    output logic [31:0]   dwdata,
    output logic [3:0]    dwe,
    output logic          dre,
    input  logic [31:0]   drdata
);

    localparam int unsigned DW  = 32;
    localparam int unsigned BEW = 4;

    logic           owner;
    logic           cand0_c;
    logic           cand1_c;
    logic           tie_to_m1_c;
    logic           win_any_c;
    logic           win_sel_c;
    logic [AW-1:0]  sel_addr_c;
    logic [DW-1:0]  sel_wdata_c;
    logic [BEW-1:0] sel_we_c;

`ifdef DMEM_ARB_RR_EN
    // Requester preferred on the next tie: the one not granted last.
    logic           rr_pref;
`endif

    // Candidate selection; a requester holding gnt this cycle is masked.
    always_comb begin
        cand0_c     = m0_req & ~m0_gnt;
        cand1_c     = m1_req & ~m1_gnt;
`ifdef DMEM_ARB_RR_EN
        tie_to_m1_c = rr_pref;
`else
        tie_to_m1_c = 1'b0;
`endif
        win_any_c   = cand0_c | cand1_c;
        win_sel_c   = cand1_c & (~cand0_c | tie_to_m1_c);
        sel_addr_c  = win_sel_c ? m1_addr  : m0_addr;
        sel_wdata_c = win_sel_c ? m1_wdata : m0_wdata;
        sel_we_c    = win_sel_c ? m1_we    : m0_we;
    end

    // Grant, memory command and read-return registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            daddr     <= '0;
            dwdata    <= '0;
            dwe       <= '0;
            dre       <= 1'b0;
            owner     <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            rr_pref   <= 1'b0;
`endif
        end else begin
            m0_gnt <= win_any_c & ~win_sel_c;
            m1_gnt <= win_any_c &  win_sel_c;
            if (win_any_c) begin
                daddr  <= sel_addr_c;
                dwdata <= sel_wdata_c;
                dwe    <= sel_we_c;
                dre    <= (sel_we_c == BEW'(0));
                // Owner only tracks reads; writes leave it untouched.
                if (sel_we_c == BEW'(0)) begin
                    owner <= win_sel_c;
                end
`ifdef DMEM_ARB_RR_EN
                rr_pref <= ~win_sel_c;
`endif
            end else begin
                dwe <= '0;
                dre <= 1'b0;
            end
            // drdata belongs to the read issued in the previous cycle.
            m0_rvalid <= dre & ~owner;
            m1_rvalid <= dre &  owner;
            m0_rdata  <= (dre & ~owner) ? drdata : DW'(0);
            m1_rdata  <= (dre &  owner) ? drdata : DW'(0);
        end
    end

endmodule
